multi_debounce: RTL and testbench

Parametrised successor to the single-button debouncer. Debounces CHANNELS independent button inputs with symmetric press/release filtering and a 2-flop synchroniser per channel. Produces debounced levels, single-cycle press/release pulses and optional hold-to-auto-repeat pulses. Sits between board button pins and game/control logic, all in the m_clock domain.

---
 rtl/multi_debounce.sv | 179 +++++++++++++++++
 tb/tb_multi_debounce.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_debounce.sv
// Multi-channel button debouncer: per-channel 2-flop synchroniser, symmetric
// press/release filter, single-cycle press/release pulses and hold-to-repeat.
module multi_debounce #(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned ACTIVE_LOW      = 1,
  parameter int unsigned REPEAT_EN       = 1,
  parameter int unsigned REPEAT_DELAY    = 1024,
  parameter int unsigned REPEAT_PERIOD   = 256
) (
  input  logic                m_clock,
  input  logic                m_reset_n,
  input  logic [CHANNELS-1:0] m_button,
  output logic [CHANNELS-1:0] m_pressed,
  output logic [CHANNELS-1:0] m_press_pulse,
  output logic [CHANNELS-1:0] m_release_pulse,
  output logic [CHANNELS-1:0] m_repeat_pulse,
  output logic                m_any_pressed
);

  localparam int unsigned DCNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RCNT_W  = $clog2(RPT_MAX + 1);

  localparam logic [DCNT_W-1:0] DCNT_LAST      = DCNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCNT_W-1:0] RPT_FIRST_LAST = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] RPT_NEXT_LAST  = RCNT_W'(REPEAT_PERIOD - 1);

  // Raw level that means "released"; also used to normalise polarity.
  localparam logic [CHANNELS-1:0] REL_LEVEL = (ACTIVE_LOW != 0) ? {CHANNELS{1'b1}} : {CHANNELS{1'b0}};

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_PRESS_CHK,
    ST_HELD,
    ST_REL_CHK
  } state_t;

  logic [CHANNELS-1:0] sync_q1;
  logic [CHANNELS-1:0] sync_q2;
  logic [CHANNELS-1:0] p_pressed;
  logic [CHANNELS-1:0] pressed_nxt;

  // Two-flop synchroniser; resets to the released level so no false press.
  always_ff @(posedge m_clock or negedge m_reset_n) begin
    if (!m_reset_n) begin
      sync_q1 <= REL_LEVEL;
      sync_q2 <= REL_LEVEL;
    end else begin
      sync_q1 <= m_button;
      sync_q2 <= sync_q1;
    end
  end

  // Polarity-normalised sample: 1 means pressed.
  assign p_pressed = sync_q2 ^ REL_LEVEL;

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    state_t              state_q;
    logic [DCNT_W-1:0]   dcnt_q;
    logic [RCNT_W-1:0]   rcnt_q;
    logic                first_q;
    logic                pressed_q;
    logic                press_q;
    logic                release_q;
    logic                repeat_q;
    logic                smp;
    logic                dcnt_last;
    logic                rpt_hit;

    assign smp       = p_pressed[g];
    assign dcnt_last = (dcnt_q == DCNT_LAST);
    assign rpt_hit   = (rcnt_q == (first_q ? RPT_FIRST_LAST : RPT_NEXT_LAST));

    // Debounce FSM with registered level and pulses. Repeat counter advances on
    // every pressed sample while the accepted level is pressed, so a release
    // bounce delays the repeat schedule by exactly the bounce length.
    always_ff @(posedge m_clock or negedge m_reset_n) begin
      if (!m_reset_n) begin
        state_q   <= ST_RELEASED;
        dcnt_q    <= '0;
        rcnt_q    <= '0;
        first_q   <= 1'b0;
        pressed_q <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
        case (state_q)
          ST_RELEASED: begin
            if (smp) begin
              state_q <= ST_PRESS_CHK;
              dcnt_q  <= DCNT_W'(1);
            end
          end
          ST_PRESS_CHK: begin
            if (!smp) begin
              state_q <= ST_RELEASED;
              dcnt_q  <= '0;
            end else if (dcnt_last) begin
              state_q   <= ST_HELD;
              dcnt_q    <= '0;
              pressed_q <= 1'b1;
              press_q   <= 1'b1;
              rcnt_q    <= '0;
              first_q   <= 1'b1;
            end else begin
              dcnt_q <= dcnt_q + DCNT_W'(1);
            end
          end
          ST_HELD: begin
            if (!smp) begin
              state_q <= ST_REL_CHK;
              dcnt_q  <= DCNT_W'(1);
            end else if (REPEAT_EN != 0) begin
              if (rpt_hit) begin
                repeat_q <= 1'b1;
                rcnt_q   <= '0;
                first_q  <= 1'b0;
              end else begin
                rcnt_q <= rcnt_q + RCNT_W'(1);
              end
            end
          end
          ST_REL_CHK: begin
            if (smp) begin
              state_q <= ST_HELD;
              dcnt_q  <= '0;
              if (REPEAT_EN != 0) begin
                if (rpt_hit) begin
                  repeat_q <= 1'b1;
                  rcnt_q   <= '0;
                  first_q  <= 1'b0;
                end else begin
                  rcnt_q <= rcnt_q + RCNT_W'(1);
                end
              end
            end else if (dcnt_last) begin
              state_q   <= ST_RELEASED;
              dcnt_q    <= '0;
              rcnt_q    <= '0;
              first_q   <= 1'b0;
              pressed_q <= 1'b0;
              release_q <= 1'b1;
            end else begin
              dcnt_q <= dcnt_q + DCNT_W'(1);
            end
          end
          default: begin
            state_q <= ST_RELEASED;
            dcnt_q  <= '0;
          end
        endcase
      end
    end

    // Level this channel will hold after the current edge.
    assign pressed_nxt[g] = ((state_q == ST_PRESS_CHK) && smp && dcnt_last) |
                            (pressed_q & ~((state_q == ST_REL_CHK) && !smp && dcnt_last));

    assign m_pressed[g]       = pressed_q;
    assign m_press_pulse[g]   = press_q;
    assign m_release_pulse[g] = release_q;
    assign m_repeat_pulse[g]  = repeat_q;
  end

  // Any-pressed flag, updated on the same edge as the per-channel levels.
  always_ff @(posedge m_clock or negedge m_reset_n) begin
    if (!m_reset_n) begin
      m_any_pressed <= 1'b0;
    end else begin
      m_any_pressed <= |pressed_nxt;
    end
  end

endmodule

// File: tb/tb_multi_debounce.sv
// Scoreboard bench for multi_debounce: directed scenarios plus random bouncing
// inputs, checked against a sample-history reference model.
module tb_multi_debounce;

  localparam int CH = 4;
  localparam int DB = 4;
  localparam int AL = 1;
  localparam int RD = 8;
  localparam int RP = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [CH-1:0] button;
  logic [CH-1:0] m_pressed;
  logic [CH-1:0] m_press_pulse;
  logic [CH-1:0] m_release_pulse;
  logic [CH-1:0] m_repeat_pulse;
  logic          m_any_pressed;

  multi_debounce #(
    .CHANNELS       (CH),
    .DEBOUNCE_CYCLES(DB),
    .ACTIVE_LOW     (AL),
    .REPEAT_EN      (1),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .m_clock        (clk),
    .m_reset_n      (rst_n),
    .m_button       (button),
    .m_pressed      (m_pressed),
    .m_press_pulse  (m_press_pulse),
    .m_release_pulse(m_release_pulse),
    .m_repeat_pulse (m_repeat_pulse),
    .m_any_pressed  (m_any_pressed)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CH-1:0] pressed;
    logic [CH-1:0] press;
    logic [CH-1:0] rel;
    logic [CH-1:0] rep;
    logic          any;
  } exp_t;

  typedef struct {
    int   cyc;
    int   sig;
    int   ch;
    logic val;
  } dchk_t;

  exp_t  exp_q[$];
  dchk_t dtab[$];
  int    checks = 0;
  int    passes = 0;
  int    cyc = 0;

  // Reference model state: 2-sample delay line and per-channel history.
  logic [CH-1:0] m_d1, m_d2, m_lvl;
  int            m_run[CH];
  int            m_held[CH];
  logic [CH-1:0] tgt;
  int            bnc[CH];

  task automatic chk(input string nm, input int unsigned act, input int unsigned expv);
    checks++;
    if (act == expv) passes++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, expv);
  endtask

  task automatic model_reset();
    m_d1  = '0;
    m_d2  = '0;
    m_lvl = '0;
    for (int c = 0; c < CH; c++) begin
      m_run[c]  = 0;
      m_held[c] = 0;
    end
  endtask

  // Level flips after DB consecutive samples disagreeing with it; repeats fire
  // on the RD-th pressed sample after acceptance and every RP samples after.
  task automatic model_step(input logic [CH-1:0] raw, output exp_t e);
    logic [CH-1:0] p;
    e    = '0;
    p    = m_d2;
    m_d2 = m_d1;
    m_d1 = (AL != 0) ? ~raw : raw;
    for (int c = 0; c < CH; c++) begin
      if (m_lvl[c] && p[c]) begin
        m_held[c]++;
        if (m_held[c] == RD || (m_held[c] > RD && ((m_held[c] - RD) % RP) == 0))
          e.rep[c] = 1'b1;
      end
      if (p[c] != m_lvl[c]) m_run[c]++;
      else m_run[c] = 0;
      if (m_run[c] == DB) begin
        m_run[c] = 0;
        m_lvl[c] = ~m_lvl[c];
        if (m_lvl[c]) begin
          e.press[c] = 1'b1;
          m_held[c]  = 0;
        end else begin
          e.rel[c] = 1'b1;
        end
      end
    end
    e.pressed = m_lvl;
    e.any     = |m_lvl;
  endtask

  // Monitor: every active cycle the DUT presents a result to compare.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("pressed", 32'(m_pressed),       32'(e.pressed));
      chk("press",   32'(m_press_pulse),   32'(e.press));
      chk("release", 32'(m_release_pulse), 32'(e.rel));
      chk("repeat",  32'(m_repeat_pulse),  32'(e.rep));
      chk("any",     32'(m_any_pressed),   32'(e.any));
    end
  end

  task automatic do_edge(input logic [CH-1:0] nb);
    exp_t e;
    @(posedge clk);
    cyc++;
    if (rst_n) begin
      model_step(button, e);
      exp_q.push_back(e);
    end
    #1;
    button = nb;
  endtask

  task automatic chk_all_zero(input string nm);
    chk(nm, 32'({m_pressed, m_press_pulse, m_release_pulse, m_repeat_pulse, m_any_pressed}), 0);
  endtask

  task automatic apply_reset(input int edges);
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    chk_all_zero("async_reset");
    model_reset();
    repeat (edges) begin
      @(posedge clk);
      cyc++;
    end
    #1;
    chk_all_zero("reset_hold");
    rst_n = 1'b1;
  endtask

  function automatic logic [CH-1:0] dir_button(input int n);
    logic [CH-1:0] b;
    b = '1;
    if (n >= 10 && n < 60) b[0] = 1'b0;
    if (n >= 15 && n <= 19) b[1] = (n == 16 || n == 19);
    else if (n >= 20 && n < 40) b[1] = 1'b0;
    if ((n >= 30 && n < 50) || (n >= 52 && n < 58) || n >= 72) b[2] = 1'b0;
    if (n >= 30 && n < 60) b[3] = 1'b0;
    return b;
  endfunction

  task automatic add_dc(input int c, input int s, input int ch, input logic v);
    dchk_t d;
    d.cyc = c; d.sig = s; d.ch = ch; d.val = v;
    dtab.push_back(d);
  endtask

  function automatic logic get_sig(input int s, input int ch);
    case (s)
      0:       return m_pressed[ch];
      1:       return m_press_pulse[ch];
      2:       return m_release_pulse[ch];
      3:       return m_repeat_pulse[ch];
      default: return m_any_pressed;
    endcase
  endfunction

  initial begin
    logic [CH-1:0] nb;
    // sig: 0 pressed, 1 press pulse, 2 release pulse, 3 repeat pulse, 4 any
    add_dc(14, 0, 0, 0); add_dc(15, 0, 0, 1); add_dc(15, 1, 0, 1); add_dc(16, 1, 0, 0);
    add_dc(15, 0, 1, 0); add_dc(15, 1, 1, 0);
    add_dc(24, 0, 1, 0); add_dc(25, 0, 1, 1); add_dc(25, 1, 1, 1); add_dc(26, 1, 1, 0);
    add_dc(35, 1, 2, 1); add_dc(35, 1, 3, 1);
    add_dc(42, 3, 2, 0); add_dc(43, 3, 2, 1); add_dc(46, 3, 2, 1); add_dc(49, 3, 2, 1);
    add_dc(52, 3, 2, 0); add_dc(53, 0, 2, 1); add_dc(53, 2, 2, 0); add_dc(54, 3, 2, 1);
    add_dc(54, 2, 2, 0); add_dc(57, 3, 2, 1);
    add_dc(44, 0, 1, 1); add_dc(45, 0, 1, 0); add_dc(45, 2, 1, 1);
    add_dc(62, 0, 2, 1); add_dc(63, 2, 2, 1); add_dc(63, 0, 2, 0);
    add_dc(64, 4, 0, 1); add_dc(65, 2, 0, 1); add_dc(65, 2, 3, 1); add_dc(65, 4, 0, 0);
    add_dc(66, 2, 0, 0);
    add_dc(77, 1, 2, 1); add_dc(85, 0, 2, 1);
    add_dc(90, 2, 2, 0); add_dc(91, 2, 2, 0); add_dc(94, 0, 2, 0);
    add_dc(95, 1, 2, 1); add_dc(95, 0, 2, 1);

    button = '1;
    rst_n  = 1'b1;
    model_reset();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset_initial");
    rst_n = 1'b1;

    // Idle with all buttons released: everything must stay 0.
    repeat (100) do_edge('1);

    // Directed scenarios, edges numbered from the reset release.
    apply_reset(2);
    cyc    = 0;
    button = dir_button(1);
    while (cyc < 120) begin
      do_edge(dir_button(cyc + 2));
      foreach (dtab[i]) begin
        if (dtab[i].cyc == cyc)
          chk($sformatf("dir_c%0d_s%0d_ch%0d", dtab[i].cyc, dtab[i].sig, dtab[i].ch),
              32'(get_sig(dtab[i].sig, dtab[i].ch)), 32'(dtab[i].val));
      end
      if (cyc == 85) begin
        apply_reset(4);
        button = dir_button(cyc + 1);
      end
    end

    // Random bouncing buttons with occasional glitches and one mid-run reset.
    tgt = button;
    for (int c = 0; c < CH; c++) bnc[c] = 0;
    for (int n = 0; n < 4000; n++) begin
      for (int c = 0; c < CH; c++) begin
        if ($urandom_range(0, 149) == 0) begin
          tgt[c] = ~tgt[c];
          bnc[c] = int'($urandom_range(0, 7));
        end
        if (bnc[c] > 0) begin
          nb[c] = 1'($urandom_range(0, 1));
          bnc[c]--;
        end else if ($urandom_range(0, 99) == 0) begin
          nb[c] = ~tgt[c];
        end else begin
          nb[c] = tgt[c];
        end
      end
      do_edge(nb);
      if (n == 2000) apply_reset(3);
    end

    @(negedge clk);
    #1;
    chk("queue_drain", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
